// File: rtl/uart_rx_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cmd_ctrl
//  Description : Parses SYNC/ADDR/DATA/CSUM byte frames from a UART receiver
//                and issues single-cycle register writes. Detects checksum
//                errors and inter-byte timeouts, and keeps frame and error
//                statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(8'hA5),
    parameter int                    TIMEOUT_CYCLES = 130208,
    parameter int                    TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_done_i,
    input  logic                  rx_busy_i,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  frame_err_o,
    output logic                  timeout_o,
    output logic                  ctrl_busy_o,
    output logic [15:0]           frame_cnt_o,
    output logic [7:0]            err_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Timer value at which the next idle cycle expires the frame
    localparam logic [TIMEOUT_WIDTH-1:0] c_term_cnt = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] c_tmr_one  = TIMEOUT_WIDTH'(1);

    state_t                  state_q;
    logic [TIMEOUT_WIDTH-1:0] timer_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    wr_en_q;
    logic [DATA_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    frame_err_q;
    logic                    timeout_q;
    logic [15:0]             frame_cnt_q;
    logic [7:0]              err_cnt_q;

    // Saturating increment shared by checksum and timeout errors
    logic [7:0] err_cnt_d;
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    // Frame parser FSM, inter-byte timer, write strobe and statistics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (rx_done_i && (rx_data_i == SYNC_BYTE)) begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR, S_DATA, S_CSUM: begin
                    if (rx_done_i) begin
                        // A byte always beats a coincident terminal count
                        timer_q <= '0;
                        case (state_q)
                            S_ADDR: begin
                                addr_q  <= rx_data_i;
                                state_q <= S_DATA;
                            end
                            S_DATA: begin
                                data_q  <= rx_data_i;
                                state_q <= S_CSUM;
                            end
                            default: begin
                                if (rx_data_i == (addr_q ^ data_q)) begin
                                    wr_en_q     <= 1'b1;
                                    wr_addr_q   <= addr_q;
                                    wr_data_q   <= data_q;
                                    frame_cnt_q <= frame_cnt_q + 16'd1;
                                    state_q     <= S_WRITE;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    err_cnt_q   <= err_cnt_d;
                                    state_q     <= S_IDLE;
                                end
                            end
                        endcase
                    end else if (rx_busy_i) begin
                        // Receiver mid-character: timer frozen, no expiry
                        timer_q <= timer_q;
                    end else if (timer_q == c_term_cnt) begin
                        timeout_q <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        timer_q   <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + c_tmr_one;
                    end
                end
                S_WRITE: begin
                    // Any byte arriving here is dropped
                    timer_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    timer_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign frame_err_o = frame_err_q;
    assign timeout_o   = timeout_q;
    assign ctrl_busy_o = (state_q != S_IDLE);
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire
